// File: rtl/load_scoreboard.sv
//------------------------------------------------------------------------------
// load_scoreboard : per-register load-use hazard tracker with an in-order
//                   outstanding-load queue. Optional: SCOREBOARD_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_scoreboard #(
  parameter int REG_NUM         = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  complete_en,
  input  logic [REG_ADDR_W-1:0] complete_rd,
  output logic                  pause,
  output logic                  full,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic [REG_ADDR_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      cnt [REG_NUM];

  logic                  empty;
  logic                  do_push;
  logic                  do_pop;
  logic                  err_set;
  logic [REG_ADDR_W-1:0] head;
  logic                  byp1;
  logic                  byp2;
  logic                  hz1;
  logic                  hz2;

  assign head    = fifo[rd_ptr];
  assign full    = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (outstanding == '0);
  assign do_pop  = complete_en && !empty;
  // A completion in the same cycle frees the slot the new load needs.
  assign do_push = issue_en && (!full || complete_en);
  assign err_set = (issue_en && full && !complete_en)
                 || (complete_en && empty)
                 || (do_pop && (complete_rd != head));

`ifdef SCOREBOARD_BYPASS_EN
  // The last pending write-back of a source is forwarded, so no stall is needed.
  assign byp1 = do_pop && (complete_rd == id_rs1) && (complete_rd == head)
             && (cnt[id_rs1] == CNT_W'(1));
  assign byp2 = do_pop && (complete_rd == id_rs2) && (complete_rd == head)
             && (cnt[id_rs2] == CNT_W'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hz1   = id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0) && !byp1;
  assign hz2   = id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0) && !byp2;
  assign pause = hz1 || hz2 || (issue_en && full && !complete_en);

  // Queue storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo[wr_ptr] <= issue_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      for (int r = 0; r < REG_NUM; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // Register 0 never becomes pending, so its counter is left at zero.
      for (int r = 1; r < REG_NUM; r++) begin
        if ((do_push && (issue_rd == REG_ADDR_W'(r)))
            && !(do_pop && (head == REG_ADDR_W'(r)))) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if ((do_pop && (head == REG_ADDR_W'(r)))
            && !(do_push && (issue_rd == REG_ADDR_W'(r)))) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_scoreboard.sv
//------------------------------------------------------------------------------
// tb_load_scoreboard : queue-based reference model and scoreboard for
//                      load_scoreboard. Honours SCOREBOARD_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_scoreboard;

  localparam int MAXO = 4;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, issue_rd = '0, complete_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       issue_en = 1'b0, complete_en = 1'b0;
  logic       pause, full, err;
  logic [2:0] outstanding;

  load_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .complete_en(complete_en), .complete_rd(complete_rd),
    .pause(pause), .full(full), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    logic       full;
    logic [2:0] occ;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];        // model: destination registers of loads in flight, oldest first
  bit   merr;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: compares the DUT outputs of every non-reset cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pause", int'(pause), int'(e.pause));
      chk("full", int'(full), int'(e.full));
      chk("outstanding", int'(outstanding), int'(e.occ));
      chk("err", int'(err), int'(e.err));
    end
  end

  function automatic int pending(int r);
    int n = 0;
    if (r == 0) return 0;
    foreach (mq[i]) if (mq[i] == r) n++;
    return n;
  endfunction

  function automatic bit hz(int src, int used, int ce, int crd);
    if (used == 0 || src == 0 || pending(src) == 0) return 1'b0;
    if (BYP && ce != 0 && crd == src && mq.size() > 0 && mq[0] == src && pending(src) == 1)
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc(int rs1, int u1, int rs2, int u2, int ie, int ird, int ce, int crd);
    exp_t e;
    bit   full_m;
    id_rs1 = 5'(rs1); id_rs1_used = (u1 != 0);
    id_rs2 = 5'(rs2); id_rs2_used = (u2 != 0);
    issue_en = (ie != 0); issue_rd = 5'(ird);
    complete_en = (ce != 0); complete_rd = 5'(crd);
    full_m  = (mq.size() == MAXO);
    e.pause = hz(rs1, u1, ce, crd) || hz(rs2, u2, ce, crd) || (ie != 0 && full_m && ce == 0);
    e.full  = full_m;
    e.occ   = 3'(mq.size());
    e.err   = merr;
    exp_q.push_back(e);
    if (ce != 0) begin
      if (mq.size() == 0) merr = 1'b1;
      else begin
        if (mq[0] != crd) merr = 1'b1;
        void'(mq.pop_front());
      end
    end
    if (ie != 0) begin
      if (!full_m || ce != 0) mq.push_back(ird);
      else merr = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_en = 1'b0; complete_en = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    merr = 1'b0;
  endtask

  initial begin
    int ie, ird, ce, crd;
    merr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // Idle after reset with a used source.
    cyc(5, 1, 0, 0, 0, 0, 0, 0);
    // Single load-use hazard.
    cyc(0, 0, 0, 0, 1, 5, 0, 0);
    cyc(5, 1, 0, 0, 0, 0, 0, 0);
    cyc(5, 1, 0, 0, 0, 0, 1, 5);
    cyc(5, 1, 0, 0, 0, 0, 0, 0);
    // Fill queue, overflow, then issue with simultaneous completion.
    cyc(0, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 1, 9, 0, 0);
    cyc(3, 1, 9, 1, 1, 2, 0, 0);
    cyc(3, 1, 0, 0, 1, 2, 1, 3);
    cyc(3, 1, 2, 1, 0, 0, 0, 0);
    cyc(3, 1, 0, 0, 0, 0, 1, 3);
    cyc(3, 1, 7, 1, 0, 0, 1, 7);
    cyc(9, 1, 2, 1, 0, 0, 1, 9);
    cyc(2, 1, 0, 0, 0, 0, 1, 2);
    cyc(2, 1, 0, 0, 0, 0, 0, 0);
    do_reset();
    // Register zero is ordered but never pending.
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Mismatched completion, completion while empty, then reset clears err.
    cyc(0, 0, 0, 0, 1, 4, 0, 0);
    cyc(4, 1, 6, 1, 0, 0, 1, 6);
    cyc(4, 1, 0, 0, 0, 0, 1, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Pointer wrap with distinct registers.
    for (int i = 1; i <= 3 * MAXO; i++) begin
      cyc(i, 1, 0, 0, 1, i, 0, 0);
      cyc(i, 1, i, 1, 0, 0, 1, i);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with periodic resets.
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 249) do_reset();
      ie  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ird = $urandom_range(0, 7);
      ce  = ((mq.size() > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 31) == 0) ? 1 : 0;
      crd = (mq.size() > 0 && $urandom_range(0, 15) != 0) ? mq[0] : $urandom_range(0, 7);
      cyc($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), ie, ird, ce, crd);
    end
    issue_en = 1'b0; complete_en = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
